// File: rtl/wb_write_queue.sv
// =============================================================================
// wb_write_queue
// -----------------------------------------------------------------------------
// Purpose:
//   Writeback-side initiator for the 16x16 register file write port. Results
//   from variable-latency producers (ALU, load unit) are buffered in an
//   in-order FIFO. At most one entry per cycle is drained into the register
//   file. A per-register pending scoreboard lets decode stall reads of
//   registers that still have queued writes.
//
// Parameters:
//   DEPTH    FIFO entries; power of two, >= 2
//   DROP_R0  1: pushes targeting R0 complete the handshake but are discarded
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous, active-high reset
//   flush        in   synchronous clear of FIFO and scoreboard
//   in_valid     in   producer has a result
//   in_ready     out  queue can accept a result this cycle
//   in_reg       in   destination register id
//   in_data      in   result value
//   hold         in   suppress draining this cycle
//   DstReg       out  register file write id (FIFO head, 0 when empty)
//   DstData      out  register file write data (FIFO head, 0 when empty)
//   WriteReg     out  register file write enable
//   SrcReg1      in   decode read id 1
//   SrcReg2      in   decode read id 2
//   Src1Pending  out  SrcReg1 has at least one queued write
//   Src2Pending  out  SrcReg2 has at least one queued write
//   count        out  number of occupied FIFO entries
// =============================================================================
module wb_write_queue #(
    parameter int DEPTH   = 4,
    parameter int DROP_R0 = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_reg,
    input  logic [15:0]                  in_data,
    input  logic                         hold,
    output logic [3:0]                   DstReg,
    output logic [15:0]                  DstData,
    output logic                         WriteReg,
    input  logic [3:0]                   SrcReg1,
    input  logic [3:0]                   SrcReg2,
    output logic                         Src1Pending,
    output logic                         Src2Pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NUM_REGS = 16;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] occupancy;

    // Entry storage. The head must be visible in the same cycle it becomes
    // valid, so the read side is asynchronous; with only DEPTH entries this
    // maps to distributed registers rather than a block RAM.
    logic [3:0]  regMem  [DEPTH];
    logic [15:0] dataMem [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake / drain control
    // -------------------------------------------------------------------------
    logic        notEmpty;
    logic        isFull;
    logic        pushFire;
    logic        dropPush;
    logic        storePush;
    logic        popFire;
    logic [3:0]  headReg;
    logic [15:0] headData;
    logic [NUM_REGS-1:0] pendingVec;

    assign notEmpty = (occupancy != '0);
    assign isFull   = (occupancy == FULL_COUNT);

    // Readiness depends only on the current occupancy: a pop in the same
    // cycle does not free a slot for a push into a full queue.
    assign in_ready = ~isFull & ~flush;
    assign pushFire = in_valid & in_ready;

    // R0 writes are architecturally meaningless when DROP_R0 is set; the
    // producer still sees a completed handshake but nothing is stored.
    assign dropPush  = (DROP_R0 != 0) && (in_reg == 4'd0);
    assign storePush = pushFire & ~dropPush;

    // The register file accepts every cycle, so a presented write is a pop.
    assign WriteReg = notEmpty & ~hold & ~flush;
    assign popFire  = WriteReg;

    assign headReg  = regMem[rdPtr];
    assign headData = dataMem[rdPtr];

    assign DstReg  = notEmpty ? headReg  : 4'd0;
    assign DstData = notEmpty ? headData : 16'd0;

    assign count = occupancy;

    // -------------------------------------------------------------------------
    // Entry storage writes (no reset needed: validity is tracked by pointers)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (storePush) begin
            regMem[wrPtr]  <= in_reg;
            dataMem[wrPtr] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (storePush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({storePush, popFire})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pending scoreboard: one small counter per architectural register.
    // A counter (not a flag) is needed because the same register may have
    // several writes in flight at once.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic [CW-1:0] cntQ;
            logic          incHit;
            logic          decHit;

            assign incHit = storePush && (in_reg == 4'(gi));
            assign decHit = popFire && (headReg == 4'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cntQ <= '0;
                end else if (flush) begin
                    cntQ <= '0;
                end else if (incHit && !decHit) begin
                    cntQ <= cntQ + CW'(1);
                end else if (decHit && !incHit) begin
                    cntQ <= cntQ - CW'(1);
                end
            end

            assign pendingVec[gi] = (cntQ != '0);
        end
    endgenerate

    assign Src1Pending = pendingVec[SrcReg1];
    assign Src2Pending = pendingVec[SrcReg2];

endmodule
